// File: rtl/adder_tree_sched.sv
// adder_tree_sched: sequences 3x3x3 adder-tree passes per pixel and accumulates on a bias.
// Optional ADDER_SCHED_RELU_EN clamps negative results to zero on the output.
module adder_tree_sched #(
    parameter int GRP_W    = 8,
    parameter int ACC_W    = 32,
    parameter int TREE_LAT = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [GRP_W-1:0] cfg_num_grp,
    input  logic [ACC_W-1:0] cfg_bias,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             tree_vld_i,
    input  logic             tree_vld_o,
    input  logic [20:0]      tree_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WD_W = $clog2(TREE_LAT + 3);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TREE_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GRP_W-1:0] r_n;
    logic [GRP_W-1:0] r_iss_cnt;
    logic [GRP_W-1:0] r_rcv_cnt;
    logic [WD_W-1:0]  r_wd;
    logic [ACC_W-1:0] r_acc;
    logic             r_err;

    logic             w_start_ok;
    logic             w_issue;
    logic             w_iss_last;
    logic             w_rcv_win;
    logic             w_rcv_full;
    logic             w_rcv;
    logic             w_rcv_last;
    logic             w_spur;
    logic             w_wd_fire;
    logic [ACC_W-1:0] w_ext;

    assign src_ready  = (r_state == S_ISSUE);
    assign tree_vld_i = src_valid & src_ready;
    assign out_valid  = (r_state == S_OUT);
    assign busy       = (r_state != S_IDLE);
    assign done       = out_valid & out_ready;
    assign err        = r_err;

    assign w_start_ok = start & (r_state == S_IDLE);
    assign w_issue    = tree_vld_i;
    assign w_iss_last = w_issue & (r_iss_cnt == r_n - 1'b1);
    assign w_rcv_win  = (r_state == S_ISSUE) | (r_state == S_DRAIN);
    assign w_rcv_full = (r_rcv_cnt == r_n);
    assign w_rcv      = tree_vld_o & w_rcv_win & ~w_rcv_full;
    assign w_rcv_last = w_rcv & (r_rcv_cnt == r_n - 1'b1);
    assign w_spur     = tree_vld_o & ~w_rcv;
    assign w_wd_fire  = (r_state == S_DRAIN) & ~tree_vld_o & (r_wd == WD_LAST);
    assign w_ext      = {{(ACC_W-21){tree_acc[20]}}, tree_acc};

`ifdef ADDER_SCHED_RELU_EN
    assign out_data = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    assign out_data = r_acc;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_iss_last) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_rcv_full | w_rcv_last | w_wd_fire)
                    w_state_nxt = S_OUT;
            end
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start takes priority so a stale error never survives into a new pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n       <= '0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
            r_wd      <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
        end else if (w_start_ok) begin
            r_n       <= (cfg_num_grp == '0) ? GRP_W'(1) : cfg_num_grp;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
            r_wd      <= '0;
            r_acc     <= cfg_bias;
            r_err     <= 1'b0;
        end else begin
            if (w_issue)
                r_iss_cnt <= r_iss_cnt + 1'b1;
            if (w_rcv) begin
                r_acc     <= r_acc + w_ext;
                r_rcv_cnt <= r_rcv_cnt + 1'b1;
            end
            if (r_state == S_DRAIN)
                r_wd <= tree_vld_o ? '0 : r_wd + 1'b1;
            if (w_spur | w_wd_fire)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: directed table, corner sequences and random pixels vs a sum model.
module tb_adder_tree_sched;

    localparam int GRP_W    = 8;
    localparam int ACC_W    = 32;
    localparam int TREE_LAT = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [GRP_W-1:0] cfg_num_grp;
    logic [ACC_W-1:0] cfg_bias;
    logic             src_valid;
    logic             src_ready;
    logic             tree_vld_i;
    logic             tree_vld_o;
    logic [20:0]      tree_acc;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;
    logic             done;
    logic             err;

    int n_vec = 0;
    int n_bad = 0;

    adder_tree_sched #(
        .GRP_W(GRP_W), .ACC_W(ACC_W), .TREE_LAT(TREE_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_num_grp(cfg_num_grp), .cfg_bias(cfg_bias),
        .src_valid(src_valid), .src_ready(src_ready),
        .tree_vld_i(tree_vld_i), .tree_vld_o(tree_vld_o),
        .tree_acc(tree_acc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ng;
        int bias;
        int nres;
        bit tog;
        int hold;
        int vals[16];
        int exp;
        bit exerr;
    } rec_t;

    rec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic rec_t mk(input int ng, input int bias, input int nres,
                                input bit tog, input int hold,
                                input int v0, input int v1, input int v2, input int v3,
                                input int exp, input bit exerr);
        rec_t r;
        r.ng = ng; r.bias = bias; r.nres = nres; r.tog = tog; r.hold = hold;
        for (int i = 0; i < 16; i++) r.vals[i] = 0;
        r.vals[0] = v0; r.vals[1] = v1; r.vals[2] = v2; r.vals[3] = v3;
        r.exp = exp; r.exerr = exerr;
        return r;
    endfunction

    // Reference: bias plus the first n returned partial sums, 32-bit wrap.
    function automatic int model(input int b, input int v[16], input int n);
        int s;
        s = b;
        for (int i = 0; i < n; i++) s = s + v[i];
`ifdef ADDER_SCHED_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic run_pix(input int ng, input int bias, input int nres,
                           input bit tog, input int hold, input int vals[16],
                           output int dat, output bit er, output int iss,
                           output int dn, output bit tmo, output bit stable,
                           output bit bsy_after);
        int q_due[$];
        int q_val[$];
        int oc;
        logic [ACC_W-1:0] hd;
        iss = 0; dn = 0; tmo = 1; oc = 0; stable = 1;
        dat = 0; er = 0; bsy_after = 1; hd = '0;
        @(negedge clk);
        start = 1'b1;
        cfg_num_grp = GRP_W'(ng);
        cfg_bias = ACC_W'(bias);
        src_valid = 1'b0; tree_vld_o = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            src_valid = tog ? ((c % 2) == 0) : 1'b1;
            tree_vld_o = 1'b0;
            tree_acc = '0;
            if (q_due.size() > 0 && q_due[0] == c) begin
                tree_vld_o = 1'b1;
                tree_acc = 21'(q_val[0]);
                void'(q_due.pop_front());
                void'(q_val.pop_front());
            end
            out_ready = 1'b0;
            if (out_valid) begin
                if (oc == 0) hd = out_data;
                else if (out_data !== hd) stable = 0;
                if (oc == 3 && hold > 0) begin
                    start = 1'b1;
                    cfg_num_grp = 9;
                end
                out_ready = (oc >= hold);
                oc++;
            end
            #1;
            if (tree_vld_i) begin
                if (iss < nres) begin
                    q_due.push_back(c + TREE_LAT);
                    q_val.push_back(vals[iss]);
                end
                iss++;
            end
            if (done) begin
                dn++;
                dat = int'($signed(out_data));
                er = err;
                tmo = 0;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0; src_valid = 1'b0; tree_vld_o = 1'b0; out_ready = 1'b0;
        #1;
        if (done) dn++;
        bsy_after = busy;
    endtask

    task automatic check_pix(input string tag, input rec_t r);
        int dat, iss, dn;
        bit er, tmo, st, ba;
        int n;
        run_pix(r.ng, r.bias, r.nres, r.tog, r.hold, r.vals,
                dat, er, iss, dn, tmo, st, ba);
        n = (r.ng == 0) ? 1 : r.ng;
        chk({tag, "_timeout"}, 64'(tmo), 64'(0));
        chk({tag, "_data"}, 64'(dat), 64'(r.exp));
        chk({tag, "_err"}, 64'(er), 64'(r.exerr));
        chk({tag, "_issues"}, 64'(iss), 64'(n));
        chk({tag, "_done"}, 64'(dn), 64'(1));
        chk({tag, "_idle"}, 64'(ba), 64'(0));
        if (r.hold > 0) chk({tag, "_stable"}, 64'(st), 64'(1));
    endtask

    initial begin
        rec_t rr;
        bit got;
        logic signed [20:0] rv;
        start = 0; cfg_num_grp = '0; cfg_bias = '0; src_valid = 0;
        tree_vld_o = 0; tree_acc = '0; out_ready = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("reset_outs",
            64'({src_ready, tree_vld_i, out_valid, busy, done, err, out_data}),
            64'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        tbl[0] = mk(1, 10, 1, 0, 0, 100, 0, 0, 0, 110, 0);
        tbl[1] = mk(4, 0, 4, 1, 0, 1000, -200, 300, -50, 1050, 0);
`ifdef ADDER_SCHED_RELU_EN
        tbl[2] = mk(2, -500, 2, 0, 0, 100, 50, 0, 0, 0, 0);
`else
        tbl[2] = mk(2, -500, 2, 0, 0, 100, 50, 0, 0, -350, 0);
`endif
        tbl[3] = mk(3, 0, 2, 0, 0, 5, 7, 0, 0, 12, 1);
        tbl[4] = mk(1, 1, 1, 0, 10, 2, 0, 0, 0, 3, 0);
        tbl[5] = mk(0, 4, 1, 0, 0, 6, 0, 0, 0, 10, 0);

        // A result in IDLE is stray: sticky error until the next start.
        @(negedge clk);
        tree_vld_o = 1'b1; tree_acc = 21'd9;
        @(negedge clk);
        tree_vld_o = 1'b0;
        #1;
        chk("stray_err", 64'(err), 64'(1));
        chk("stray_idle", 64'(busy), 64'(0));

        for (int i = 0; i < 6; i++)
            check_pix($sformatf("tbl%0d", i), tbl[i]);

        // Reset during DRAIN drops everything in flight.
        @(negedge clk);
        start = 1'b1; cfg_num_grp = 8; cfg_bias = 0;
        @(negedge clk);
        start = 1'b0; src_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (busy && !src_ready) got = 1;
        end
        chk("reach_drain", 64'(got), 64'(1));
        rstn = 1'b0;
        #1;
        chk("midrst_outs",
            64'({src_ready, tree_vld_i, out_valid, busy, done, err, out_data}),
            64'(0));
        @(negedge clk);
        rstn = 1'b1; src_valid = 1'b0;
        check_pix("post_rst", mk(1, 7, 1, 0, 0, 3, 0, 0, 0, 10, 0));

        for (int k = 0; k < 20; k++) begin
            rr = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            rr.ng = int'($urandom_range(1, 6));
            rr.nres = rr.ng;
            rr.bias = int'($urandom);
            rr.tog = 1'($urandom);
            rr.hold = int'($urandom_range(0, 3));
            for (int j = 0; j < rr.ng; j++) begin
                rv = 21'($urandom);
                rr.vals[j] = int'(rv);
            end
            rr.exp = model(rr.bias, rr.vals, rr.ng);
            check_pix($sformatf("rnd%0d", k), rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
